// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard unit: select-width helper,
// default pipe-entry layout and the register-file select code.
// Optional stats counters are enabled by defining FWD_STATS_EN.
`ifndef FWD_REG_ADDR_W
`define FWD_REG_ADDR_W 5
`endif
`ifndef FWD_NUM_SRC
`define FWD_NUM_SRC 2
`endif

package fwd_pkg;

  // fwd_sel code meaning "take the operand from the register file"
  localparam int SEL_RF = 0;

  // Width of one fwd_sel field: must encode 0..depth, never narrower than 1
  function automatic int fwd_sel_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // Tracking-pipe entry for the default address width / source count
  typedef struct packed {
    logic                                         valid;
    logic                                         regwrite;
    logic                                         memread;
    logic [`FWD_REG_ADDR_W-1:0]                   rd;
    logic [`FWD_NUM_SRC-1:0][`FWD_REG_ADDR_W-1:0] src;
  } pipe_entry_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage issue bus into the forwarding/hazard unit and its EX-side outputs.
// FWD_STATS_EN adds the stall/forward event counters to the bundle.
interface fwd_hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2
);
  localparam int SEL_W = fwd_pkg::fwd_sel_w(FWD_DEPTH);

  logic                          issue_valid;
  logic [REG_ADDR_W-1:0]         issue_rd;
  logic                          issue_regwrite;
  logic                          issue_memread;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
  logic                          flush;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
  logic                          stall;
`ifdef FWD_STATS_EN
  logic [31:0]                   stall_cycles;
  logic [31:0]                   fwd_events;
`endif

  modport master (
    output issue_valid, issue_rd, issue_regwrite, issue_memread, id_src, flush,
    input  fwd_sel, stall
`ifdef FWD_STATS_EN
    , input stall_cycles, fwd_events
`endif
  );

  modport slave (
    input  issue_valid, issue_rd, issue_regwrite, issue_memread, id_src, flush,
    output fwd_sel, stall
`ifdef FWD_STATS_EN
    , output stall_cycles, fwd_events
`endif
  );

endinterface

// File: rtl/fwd_hazard_unit_match.sv
// fwd_match: nearest-producer priority search over a window of pipe entries.
// Element j of the window is reported as stage BASE+j; readiness compares
// that stage against LOAD_LAT so the same block serves both the EX forward
// decision (BASE=1 over pipe[1..]) and the ID stall decision (BASE=1 over
// pipe[0..], i.e. the stage the producer will occupy when the consumer is in EX).
module fwd_match
  import fwd_pkg::*;
#(
  parameter int AW       = 5,
  parameter int N        = 2,
  parameter int BASE     = 1,
  parameter int LOAD_LAT = 2,
  parameter int SW       = 2
) (
  input  logic [AW-1:0]        addr,
  input  logic [N-1:0]         wr,
  input  logic [N-1:0]         ld,
  input  logic [N-1:0][AW-1:0] rd,
  output logic                 found,
  output logic [SW-1:0]        stage,
  output logic                 ready
);

  // Walk oldest to youngest so the nearest matching producer wins last
  always_comb begin
    found = 1'b0;
    stage = SW'(SEL_RF);
    ready = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (wr[j] && (rd[j] == addr) && (addr != '0)) begin
        found = 1'b1;
        stage = SW'(BASE + j);
        ready = !ld[j] || ((BASE + j) >= LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: tracks in-flight destinations from EX onward, picks the
// nearest ready forwarding stage per EX operand and raises stall on load-use.
// Defining FWD_STATS_EN adds saturating stall_cycles / fwd_events counters.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = `FWD_REG_ADDR_W,
  parameter int NUM_SRC    = `FWD_NUM_SRC,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  fwd_hazard_unit_if.slave bus
);
  localparam int SEL_W = fwd_sel_w(FWD_DEPTH);

  typedef struct packed {
    logic                               valid;
    logic                               regwrite;
    logic                               memread;
    logic [REG_ADDR_W-1:0]              rd;
    logic [NUM_SRC-1:0][REG_ADDR_W-1:0] src;
  } entry_t;

  entry_t pipe [0:FWD_DEPTH];
  entry_t issue_entry;
  logic   stall;

  logic [FWD_DEPTH-1:0]                 wr_f, ld_f, wr_s, ld_s;
  logic [FWD_DEPTH-1:0][REG_ADDR_W-1:0] rd_f, rd_s;
  logic [NUM_SRC-1:0]                   f_found, f_ready, s_found, s_ready, stall_src;
  logic [NUM_SRC-1:0][SEL_W-1:0]        f_stage, s_stage, sel;

  // Entry entering EX: flush or stall turns it into a bubble
  always_comb begin
    issue_entry          = '0;
    issue_entry.valid    = bus.issue_valid & ~stall & ~bus.flush;
    issue_entry.regwrite = bus.issue_regwrite;
    issue_entry.memread  = bus.issue_memread;
    issue_entry.rd       = bus.issue_rd;
    issue_entry.src      = bus.id_src;
  end

  // Tracking pipe shifts every cycle; reset clears all entries
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int k = 0; k <= FWD_DEPTH; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= issue_entry;
      for (int k = 1; k <= FWD_DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end

  // Producer windows: pipe[1..D] for EX forwarding, pipe[0..D-1] for ID hazards
  always_comb begin
    wr_f = '0; ld_f = '0; rd_f = '0;
    wr_s = '0; ld_s = '0; rd_s = '0;
    for (int j = 0; j < FWD_DEPTH; j++) begin
      wr_f[j] = pipe[j+1].valid & pipe[j+1].regwrite;
      ld_f[j] = pipe[j+1].memread;
      rd_f[j] = pipe[j+1].rd;
      wr_s[j] = pipe[j].valid & pipe[j].regwrite;
      ld_s[j] = pipe[j].memread;
      rd_s[j] = pipe[j].rd;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_ADDR_W-1:0] id_addr;
    assign id_addr = bus.id_src[i*REG_ADDR_W +: REG_ADDR_W];

    fwd_match #(
      .AW(REG_ADDR_W), .N(FWD_DEPTH), .BASE(1), .LOAD_LAT(LOAD_LAT), .SW(SEL_W)
    ) u_fwd (
      .addr (pipe[0].src[i]),
      .wr   (wr_f),
      .ld   (ld_f),
      .rd   (rd_f),
      .found(f_found[i]),
      .stage(f_stage[i]),
      .ready(f_ready[i])
    );

    fwd_match #(
      .AW(REG_ADDR_W), .N(FWD_DEPTH), .BASE(1), .LOAD_LAT(LOAD_LAT), .SW(SEL_W)
    ) u_haz (
      .addr (id_addr),
      .wr   (wr_s),
      .ld   (ld_s),
      .rd   (rd_s),
      .found(s_found[i]),
      .stage(s_stage[i]),
      .ready(s_ready[i])
    );

    // A nearest producer that is not yet ready falls back to the register file
    assign sel[i]       = (pipe[0].valid && f_found[i] && f_ready[i]) ? f_stage[i]
                                                                      : SEL_W'(SEL_RF);
    assign stall_src[i] = s_found[i] & ~s_ready[i];
  end

  assign stall       = |stall_src;
  assign bus.stall   = stall;
  assign bus.fwd_sel = sel;

`ifdef FWD_STATS_EN
  logic [31:0] stall_cycles, fwd_events, nz;
  logic [32:0] fwd_sum;

  // Number of operands actually forwarded this cycle
  always_comb begin
    nz = '0;
    for (int i = 0; i < NUM_SRC; i++) nz = nz + 32'(sel[i] != '0);
  end

  assign fwd_sum = {1'b0, fwd_events} + {1'b0, nz};

  // Saturating event counters
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      fwd_events <= fwd_sum[32] ? '1 : fwd_sum[31:0];
    end
  end

  assign bus.stall_cycles = stall_cycles;
  assign bus.fwd_events   = fwd_events;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed table-driven bench: dut_a uses LOAD_LAT=2, dut_b uses LOAD_LAT=1.
// Each row drives ID inputs, checks stall (from those inputs) and fwd_sel
// (for the instruction currently in EX), then clocks once.
module tb_fwd_hazard_unit;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  fwd_hazard_unit_if #(.REG_ADDR_W(5), .NUM_SRC(2), .FWD_DEPTH(2)) ifa ();
  fwd_hazard_unit_if #(.REG_ADDR_W(5), .NUM_SRC(2), .FWD_DEPTH(2)) ifb ();

  fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_LAT(2))
    dut_a (.Clk(Clk), .Reset(Reset), .bus(ifa));
  fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_LAT(1))
    dut_b (.Clk(Clk), .Reset(Reset), .bus(ifb));

  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       rw, ld;
    logic [4:0] s0, s1;
    logic       fl, rst;
    logic [1:0] e0, e1;
    logic       est;
  } vec_t;

  int passed = 0;
  int total  = 0;

  function automatic vec_t mk(input logic v, input logic [4:0] rd, input logic rw,
                              input logic ld, input logic [4:0] s0, input logic [4:0] s1,
                              input logic fl, input logic rst, input logic [1:0] e0,
                              input logic [1:0] e1, input logic est);
    vec_t r;
    r.v = v; r.rd = rd; r.rw = rw; r.ld = ld; r.s0 = s0; r.s1 = s1;
    r.fl = fl; r.rst = rst; r.e0 = e0; r.e1 = e1; r.est = est;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    Reset              = r.rst;
    ifa.issue_valid    = r.v;  ifb.issue_valid    = r.v;
    ifa.issue_rd       = r.rd; ifb.issue_rd       = r.rd;
    ifa.issue_regwrite = r.rw; ifb.issue_regwrite = r.rw;
    ifa.issue_memread  = r.ld; ifb.issue_memread  = r.ld;
    ifa.id_src         = {r.s1, r.s0};
    ifb.id_src         = {r.s1, r.s0};
    ifa.flush          = r.fl; ifb.flush          = r.fl;
  endtask

  task automatic run_row(input string tag, input int idx, input vec_t r, input bit use_b);
    logic [3:0] got_sel;
    logic       got_stall;
    drive(r);
    #1;
    got_sel   = use_b ? ifb.fwd_sel : ifa.fwd_sel;
    got_stall = use_b ? ifb.stall   : ifa.stall;
    total++;
    if (got_sel === {r.e1, r.e0}) passed++;
    else $display("FAIL %s[%0d] fwd_sel got=%h want=%h", tag, idx, got_sel, {r.e1, r.e0});
    total++;
    if (got_stall === r.est) passed++;
    else $display("FAIL %s[%0d] stall got=%b want=%b", tag, idx, got_stall, r.est);
    @(negedge Clk);
  endtask

  vec_t ta[$];
  vec_t tb[$];
  vec_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // ALU rd3 consumed from EX/MEM then MEM/WB
    ta.push_back(mk(1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(1, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(1, 0, 0, 0, 0, 3, 0, 1, 1, 0, 0));
    ta.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0));
    // Two writers of rd4: nearest wins
    ta.push_back(mk(1, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(1, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(1, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    // Load rd5 then immediate use: one stall cycle, then forward from stage 2
    ta.push_back(mk(1, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(1, 0, 0, 0, 5, 0, 0, 1, 0, 0, 1));
    ta.push_back(mk(1, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    // r0 writer and non-writing rd7 never forward
    ta.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    ta.push_back(idle);
    ta.push_back(mk(1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(1, 0, 0, 0, 7, 0, 0, 1, 0, 0, 0));
    ta.push_back(idle);
    // Load rd6 shadowed by younger ALU rd6
    ta.push_back(mk(1, 6, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(1, 0, 0, 0, 6, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    // Three valid entries, load-use stall on src1, reset in the stall cycle
    ta.push_back(mk(1, 10, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(1, 11, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(1, 9, 1, 1, 11, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(1, 0, 0, 0, 0, 9, 0, 0, 1, 0, 1));
    ta.push_back(mk(1, 0, 0, 0, 0, 9, 0, 1, 0, 0, 0));
    ta.push_back(idle);
    // Flushed load rd8 never causes a stall or a forward
    ta.push_back(mk(1, 8, 1, 1, 0, 0, 1, 1, 0, 0, 0));
    ta.push_back(mk(1, 0, 0, 0, 8, 0, 0, 1, 0, 0, 0));
    ta.push_back(idle);
    // Stall and flush together: stall still reported, bubble inserted
    ta.push_back(mk(1, 12, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(1, 0, 0, 0, 12, 0, 1, 1, 0, 0, 1));
    ta.push_back(mk(1, 0, 0, 0, 12, 0, 0, 1, 0, 0, 0));
    ta.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));

    // LOAD_LAT=1: load result forwardable from EX/MEM, no stall
    tb.push_back(mk(1, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    tb.push_back(mk(1, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0));
    tb.push_back(mk(1, 0, 0, 0, 0, 5, 0, 1, 1, 0, 0));
    tb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0));

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge Clk);

    for (int i = 0; i < ta.size(); i++) run_row("a", i, ta[i], 1'b0);

    // Fresh reset before the LOAD_LAT=1 sequence
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge Clk);
    for (int i = 0; i < tb.size(); i++) run_row("b", i, tb[i], 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
